// File: rtl/pic_ack_eoi_sequencer.sv
// 8259A acknowledge / end-of-interrupt sequencer: runs the two-pulse INTA
// handshake, decodes OCW2 EOI/rotate commands, drives ISR set/clear masks.
module pic_ack_eoi_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic [7:0] interrupt_request_highest,
  input  logic [7:0] in_service_register,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic [7:0] acknowledge_interrupt,
  output logic       latch_in_service,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } state_t;

  state_t     state;
  logic       inta_prev;
  // Set once inta_n has been seen high; blocks a false fall when
  // inta_n is held low through reset release.
  logic       inta_armed;
  logic       rotate_on_aeoi;
  logic       spurious;
  logic [2:0] level;

  logic       fall;
  logic       rise;
  logic       his_valid;
  logic [2:0] his_level;
  logic [2:0] scan_lvl;
  logic [2:0] req_idx;
  logic [7:0] ocw_clear;
  logic       ocw_rot_en;
  logic [2:0] ocw_rot_val;
  logic       ocw_raeoi_wr;
  logic       aeoi_fire;
  logic [7:0] aeoi_mask;
  logic [2:0] ocw_l;

  assign fall  = inta_prev & ~inta_n & inta_armed;
  assign rise  = ~inta_prev & inta_n;
  assign ocw_l = ocw2_data[2:0];

  // Highest in service: first ISR bit scanning up from rotate+1.
  always_comb begin
    his_valid = 1'b0;
    his_level = 3'd0;
    scan_lvl  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      scan_lvl = priority_rotate + 3'(k) + 3'd1;
      if (in_service_register[scan_lvl]) begin
        his_valid = 1'b1;
        his_level = scan_lvl;
      end
    end
  end

  always_comb begin
    req_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (interrupt_request_highest[i]) req_idx = 3'(i);
    end
  end

  always_comb begin
    ocw_clear    = 8'h00;
    ocw_rot_en   = 1'b0;
    ocw_rot_val  = ocw_l;
    ocw_raeoi_wr = 1'b0;
    if (ocw2_write) begin
      unique case (ocw2_data[7:5])
        3'b001: if (his_valid) ocw_clear = 8'h01 << his_level;
        3'b011: ocw_clear = 8'h01 << ocw_l;
        3'b101: begin
          if (his_valid) begin
            ocw_clear   = 8'h01 << his_level;
            ocw_rot_en  = 1'b1;
            ocw_rot_val = his_level;
          end
        end
        3'b111: begin
          ocw_clear  = 8'h01 << ocw_l;
          ocw_rot_en = 1'b1;
        end
        3'b110: ocw_rot_en = 1'b1;
        3'b100: ocw_raeoi_wr = 1'b1;
        3'b000: ocw_raeoi_wr = 1'b1;
        default: ;
      endcase
    end
  end

  assign aeoi_fire = (state == ACK2) & rise & auto_eoi & ~spurious;
  assign aeoi_mask = aeoi_fire ? (8'h01 << level) : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      inta_prev             <= 1'b1;
      inta_armed            <= inta_n;
      rotate_on_aeoi        <= 1'b0;
      spurious              <= 1'b0;
      level                 <= 3'd0;
      acknowledge_interrupt <= 8'h00;
      latch_in_service      <= 1'b0;
      end_of_interrupt      <= 8'h00;
      priority_rotate       <= 3'd7;
      data_out              <= 8'h00;
      data_out_en           <= 1'b0;
    end else begin
      inta_prev             <= inta_n;
      inta_armed            <= inta_armed | inta_n;
      acknowledge_interrupt <= 8'h00;
      latch_in_service      <= 1'b0;
      end_of_interrupt      <= ocw_clear | aeoi_mask;

      // OCW2 rotation overrides an AEOI rotation in the same cycle.
      if (ocw_rot_en)
        priority_rotate <= ocw_rot_val;
      else if (aeoi_fire && rotate_on_aeoi)
        priority_rotate <= level;

      if (ocw_raeoi_wr) rotate_on_aeoi <= ocw2_data[7];

      unique case (state)
        IDLE: begin
          if (fall) begin
            if (interrupt_request_highest != 8'h00) begin
              acknowledge_interrupt <= interrupt_request_highest;
              latch_in_service      <= 1'b1;
              level                 <= req_idx;
              spurious              <= 1'b0;
            end else begin
              spurious <= 1'b1;
              level    <= 3'd7;
            end
            state <= ACK1;
          end
        end
        ACK1: if (rise) state <= WAIT2;
        WAIT2: begin
          if (fall) begin
            data_out    <= {vector_base, level};
            data_out_en <= 1'b1;
            state       <= ACK2;
          end
        end
        ACK2: begin
          if (rise) begin
            data_out_en <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_ack_eoi_sequencer.sv
// Self-checking bench for pic_ack_eoi_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_pic_ack_eoi_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic [7:0] req;
  logic [7:0] isr;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic [7:0] acknowledge_interrupt;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pic_ack_eoi_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .inta_n                   (inta_n),
    .interrupt_request_highest(req),
    .in_service_register      (isr),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .acknowledge_interrupt    (acknowledge_interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the acknowledge is tracked as a count of INTA
  // edges seen (0..3); outputs are what the rules demand after each edge.
  int         m_stage;
  bit         m_prev;
  bit         m_seen_high;
  bit         m_raeoi;
  bit         m_spur;
  int         m_level;
  int         m_rot;
  logic [7:0] m_ack;
  bit         m_latch;
  logic [7:0] m_eoi;
  logic [7:0] m_dout;
  bit         m_den;
  bit         started = 0;

  always @(posedge clk) begin : model
    int         his;
    int         l;
    int         nrot;
    bit         fall;
    bit         rise;
    logic [7:0] clr;
    started = 1;
    if (!rst_n) begin
      m_stage = 0; m_prev = 1; m_seen_high = inta_n;
      m_raeoi = 0; m_spur = 0; m_level = 0; m_rot = 7;
      m_ack = 0; m_latch = 0; m_eoi = 0; m_dout = 0; m_den = 0;
    end else begin
      fall = m_prev && !inta_n && m_seen_high;
      rise = !m_prev && inta_n;
      his = -1;
      for (int k = 0; k < 8; k++)
        if (his < 0 && isr[(m_rot + 1 + k) % 8]) his = (m_rot + 1 + k) % 8;
      clr = 0; nrot = m_rot; m_ack = 0; m_latch = 0;
      case (m_stage)
        0: if (fall) begin
          if (req != 0) begin
            m_ack = req; m_latch = 1; m_spur = 0;
            for (int i = 0; i < 8; i++) if (req[i]) m_level = i;
          end else begin
            m_spur = 1; m_level = 7;
          end
          m_stage = 1;
        end
        1: if (rise) m_stage = 2;
        2: if (fall) begin
          m_dout = 8'(vector_base * 8 + m_level);
          m_den = 1; m_stage = 3;
        end
        default: if (rise) begin
          m_den = 0; m_stage = 0;
          if (auto_eoi && !m_spur) begin
            clr = 8'(1 << m_level);
            if (m_raeoi) nrot = m_level;
          end
        end
      endcase
      if (ocw2_write) begin
        l = int'(ocw2_data[2:0]);
        if (ocw2_data[5]) begin
          if (ocw2_data[6]) begin
            clr |= 8'(1 << l);
            if (ocw2_data[7]) nrot = l;
          end else if (his >= 0) begin
            clr |= 8'(1 << his);
            if (ocw2_data[7]) nrot = his;
          end
        end else if (ocw2_data[7] && ocw2_data[6]) begin
          nrot = l;
        end else if (!ocw2_data[6]) begin
          m_raeoi = ocw2_data[7];
        end
      end
      m_eoi = clr; m_rot = nrot;
      m_prev = inta_n;
      m_seen_high = m_seen_high || inta_n;
    end
  end

  int         rec_latch_cnt;
  int         rec_eoi_cnt;
  logic [7:0] rec_ack;
  logic [7:0] rec_dout;
  logic [7:0] rec_eoi;

  always @(negedge clk) begin
    if (started) begin
      chk("ack", acknowledge_interrupt, m_ack);
      chk("latch", latch_in_service, m_latch);
      chk("eoi", end_of_interrupt, m_eoi);
      chk("rotate", priority_rotate, m_rot);
      chk("dout", data_out, m_dout);
      chk("dout_en", data_out_en, m_den);
      if (latch_in_service) begin
        rec_latch_cnt++;
        rec_ack = acknowledge_interrupt;
      end
      if (data_out_en) rec_dout = data_out;
      if (end_of_interrupt != 0) begin
        rec_eoi_cnt++;
        rec_eoi |= end_of_interrupt;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rec();
    rec_latch_cnt = 0; rec_eoi_cnt = 0;
    rec_ack = 0; rec_dout = 0; rec_eoi = 0;
  endtask

  task automatic ocw(input logic [7:0] b);
    ocw2_write = 1; ocw2_data = b;
    tick();
    ocw2_write = 0;
  endtask

  task automatic ack_seq(input logic [7:0] r);
    req = r;
    inta_n = 0; tick(2);
    inta_n = 1; tick(2);
    inta_n = 0; tick(2);
    inta_n = 1; tick(3);
  endtask

  initial begin
    rst_n = 0; inta_n = 1; req = 0; isr = 0;
    vector_base = 5'h12; auto_eoi = 0;
    ocw2_write = 0; ocw2_data = 0;
    clear_rec();
    tick(3);
    chk("reset_rotate", priority_rotate, 7);
    chk("reset_den", data_out_en, 0);
    rst_n = 1;
    tick(2);

    // normal acknowledge
    clear_rec();
    ack_seq(8'h08);
    chk("norm_latch_cnt", rec_latch_cnt, 1);
    chk("norm_ack", rec_ack, 8'h08);
    chk("norm_dout", rec_dout, 8'h93);
    chk("norm_no_eoi", rec_eoi_cnt, 0);

    // AEOI with rotation
    auto_eoi = 1;
    ocw(8'h80);
    clear_rec();
    ack_seq(8'h20);
    chk("aeoi_eoi", rec_eoi, 8'h20);
    chk("aeoi_eoi_cnt", rec_eoi_cnt, 1);
    chk("aeoi_rotate", priority_rotate, 5);

    // spurious acknowledge
    clear_rec();
    ack_seq(8'h00);
    chk("spur_latch_cnt", rec_latch_cnt, 0);
    chk("spur_dout", rec_dout, 8'h97);
    chk("spur_no_eoi", rec_eoi_cnt, 0);

    // non-specific EOI under rotation
    ocw(8'hC3);
    tick();
    chk("setprio_rotate", priority_rotate, 3);
    isr = 8'h21;
    clear_rec();
    ocw(8'hA0);
    tick(2);
    chk("nseoi_eoi", rec_eoi, 8'h20);
    chk("nseoi_rotate", priority_rotate, 5);
    isr = 0;

    // specific EOI colliding with AEOI clear of level 0
    clear_rec();
    req = 8'h01;
    inta_n = 0; tick(2);
    inta_n = 1; tick(2);
    inta_n = 0; tick(2);
    inta_n = 1; ocw2_write = 1; ocw2_data = 8'h62;
    tick();
    ocw2_write = 0;
    tick(2);
    chk("coll_eoi", rec_eoi, 8'h05);
    chk("coll_eoi_cnt", rec_eoi_cnt, 1);

    // reset in WAIT2 with inta_n low
    req = 8'h04;
    inta_n = 0; tick(2);
    inta_n = 1; tick(2);
    clear_rec();
    rst_n = 0; inta_n = 0;
    tick(2);
    chk("rst_rotate", priority_rotate, 7);
    chk("rst_den", data_out_en, 0);
    chk("rst_eoi", end_of_interrupt, 0);
    rst_n = 1;
    tick(3);
    chk("rst_hold_latch", rec_latch_cnt, 0);
    chk("rst_hold_den", data_out_en, 0);
    inta_n = 1; tick(2);
    ack_seq(8'h04);
    chk("rst_after_latch", rec_latch_cnt, 1);
    chk("rst_after_dout", rec_dout, 8'h92);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      req = ($urandom_range(0, 3) == 0) ? 8'h00
                                        : 8'(1 << $urandom_range(0, 7));
      isr = 8'($urandom);
      vector_base = 5'($urandom);
      if ($urandom_range(0, 49) == 0) auto_eoi = ~auto_eoi;
      ocw2_write = ($urandom_range(0, 5) == 0);
      ocw2_data = 8'($urandom);
      tick();
    end
    rst_n = 1; ocw2_write = 0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
